// File: rtl/ex_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_pkg
// Description : Shared definitions for the EX-stage divider: FSM state codes,
//               start/ready encodings, the zero word and a negate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_div_pkg;

    // Divider FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    // Two's-complement negation of a 32-bit word
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_div
// Description : Multi-cycle 32-bit restoring divider for DIV/DIVU. One
//               quotient bit per cycle; 33 cycles from start to ready.
// Ports       : clk, rst          - clock, async active-high reset
//               signed_div_i      - 1 = signed (DIV), 0 = unsigned (DIVU)
//               opdata1_i/2_i     - dividend / divisor, sampled with start
//               start_i, annul_i  - request (held until ready), abort
//               result_o          - {remainder, quotient}
//               ready_o           - result valid
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div
    import ex_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_q,  state_d;
    logic [31:0] dvd_q,    dvd_d;     // |dividend|, shifts into quotient
    logic [31:0] dvs_q,    dvs_d;     // |divisor|
    logic [32:0] rem_q,    rem_d;     // partial remainder
    logic [5:0]  cnt_q,    cnt_d;
    logic        sa_q,     sa_d;
    logic        sb_q,     sb_d;
    logic [63:0] result_q, result_d;
    logic        ready_q,  ready_d;

    logic [32:0] w_t;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_t    = {rem_q[31:0], dvd_q[31]};
    assign w_diff = w_t - {1'b0, dvs_q};
    // The remainder always stays below the divisor, so rem_q[32] is 0 in
    // practice; if it were set, the true trial value would exceed D anyway.
    assign w_ge   = rem_q[32] | (w_t >= {1'b0, dvs_q});

    // Quotient sign follows sa^sb; remainder sign follows the dividend.
    assign w_quo  = (sa_q ^ sb_q) ? neg32(dvd_q) : dvd_q;
    assign w_rem  = sa_q ? neg32(rem_q[31:0]) : rem_q[31:0];

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            DivFree: begin
                // annul has priority over a simultaneous start
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == ZeroWord) begin
                        state_d = DivByZero;
                    end else begin
                        state_d = DivOn;
                        dvd_d   = (signed_div_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
                        dvs_d   = (signed_div_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
                        sa_d    = signed_div_i & opdata1_i[31];
                        sb_d    = signed_div_i & opdata2_i[31];
                        rem_d   = 33'd0;
                        cnt_d   = 6'd0;
                    end
                end
            end
            DivByZero: begin
                state_d  = DivEnd;
                result_d = {ZeroWord, ZeroWord};
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d  = DivFree;
                    result_d = {ZeroWord, ZeroWord};
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != 6'd32) begin
                    dvd_d = {dvd_q[30:0], w_ge};
                    rem_d = w_ge ? w_diff : w_t;
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    state_d  = DivEnd;
                    result_d = {w_rem, w_quo};
                    ready_d  = DivResultReady;
                end
            end
            DivEnd: begin
                // Result is held until EX drops start after seeing ready
                if (start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = {ZeroWord, ZeroWord};
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DivFree;
            dvd_q    <= ZeroWord;
            dvs_q    <= ZeroWord;
            rem_q    <= 33'd0;
            cnt_q    <= 6'd0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= {ZeroWord, ZeroWord};
            ready_q  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_div
// Description : Self-checking bench for ex_div: directed cases plus random
//               divides compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'h0;
    logic [31:0] opdata2_i = 32'h0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int errors = 0;

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {remainder, quotient}; signed math truncates toward zero with
    // the remainder taking the dividend's sign. 64-bit math covers INT_MIN/-1.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q  = x / y;
        r  = x % y;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Issue one divide (call just after a rising edge), scramble operands while
    // busy, then check latency, result, hold while start stays high, and clear.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int exp_lat);
        int n;
        logic [63:0] held;
        start_i      = 1'b1;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end while (!ready_o && n < 45);
        chk({tag, "_latency"}, 64'(n - 1), 64'(exp_lat));
        chk({tag, "_result"}, result_o, exp);
        held = result_o;
        @(posedge clk); #1;
        chk({tag, "_hold"}, {63'h0, ready_o}, 64'h1);
        chk({tag, "_holdres"}, result_o, held);
        start_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_clrrdy"}, {63'h0, ready_o}, 64'h0);
        chk({tag, "_clrres"}, result_o, 64'h0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic        saw_ready;

        // Reset state
        #12;
        chk("reset_ready", {63'h0, ready_o}, 64'h0);
        chk("reset_result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Unsigned 100 / 7
        do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

        // Signed cases
        do_div("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div("s_7_m2", 32'h7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33);

        // Divide by zero
        do_div("dz", 32'h1234_5678, 32'h0, 1'b1, 64'h0, 1);

        // Annul at iteration 10, then immediate new start
        start_i = 1'b1; opdata1_i = 32'd123456; opdata2_i = 32'd789; signed_div_i = 1'b0;
        saw_ready = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
            saw_ready = saw_ready | ready_o;
        end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        saw_ready = saw_ready | ready_o;
        chk("annul_noready", {63'h0, saw_ready}, 64'h0);
        chk("annul_result", result_o, 64'h0);
        do_div("post_annul", 32'hFFFF_FFFF, 32'h10, 1'b0, {32'hF, 32'h0FFF_FFFF}, 33);

        // Signed overflow
        do_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);

        // Annul and start together in DivFree: no start
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("annul_start_free", {63'h0, ready_o}, 64'h0);
        annul_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;

        // Async reset at iteration 20
        start_i = 1'b1; opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0;
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("areset_ready", {63'h0, ready_o}, 64'h0);
        chk("areset_result", result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Async reset while a result is being held
        start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        chk("held_ready", {63'h0, ready_o}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("held_rst_ready", {63'h0, ready_o}, 64'h0);
        chk("held_rst_result", result_o, 64'h0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div("post_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0, 32'h1}, 33);

        // Random divides against the reference model
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = {16'h0, 16'($urandom)};
                default: b = -32'($urandom_range(1, 100));
            endcase
            s = 1'(i % 2);
            do_div("rand", a, b, s, ref_div(a, b, s), (b == 32'h0) ? 1 : 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
